b1to4_tdm_demuxer: RTL and testbench
====================================

B1TO4_TDM_DEMUXER -- requirements
Module: b1to4_tdm_demuxer

Interface
REQ-001 Parameter: W, 8, bit width of one channel sample.
REQ-002 Port: clock  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: x0  input  W  time-multiplexed sample stream, one channel sample per valid cycle.
REQ-005 Port: valid  input  1  x0 carries a sample this cycle.
REQ-006 Port: sync  input  1  frame marker; when high with valid, x0 is the channel-0 sample.
REQ-007 Port: z3_z0  output  4*W  last complete frame; channel k at bits [k*W+W-1 : k*W].
REQ-008 Port: b1_b0  output  2  slot index the next valid sample will be written to.
REQ-009 Port: frame_ok  output  1  one-cycle pulse: z3_z0 updated with a new complete frame.
REQ-010 Port: sync_err  output  1  one-cycle pulse: framing violation detected.
REQ-011 Port: locked  output  1  block is in RECV state.

Function
REQ-012 The block SHALL have two states: HUNT (waiting for a frame marker) and RECV (collecting a frame).
REQ-013 All inputs SHALL be ignored on any cycle with valid low: no state, counter, or output-register change, and no pulse.
REQ-014 In HUNT, a valid sample with sync low SHALL be discarded, with no pulse.
REQ-015 In HUNT, a valid sample with sync high SHALL be written to staging slot 0, set b1_b0 to 1, and move the block to RECV.
REQ-016 In RECV, a valid sample with sync low SHALL be written to staging slot b1_b0, and b1_b0 SHALL increment modulo 4.
REQ-017 When the slot-3 sample is accepted, the full staging frame, including that sample, SHALL be copied to z3_z0 on the same edge.
REQ-018 On that same edge, frame_ok SHALL be set high for exactly the following cycle, and b1_b0 SHALL wrap to 0.
REQ-019 Latency: z3_z0 and frame_ok SHALL be visible one cycle after the slot-3 sample is presented.
REQ-020 In RECV with b1_b0 = 0, a valid sample with sync high SHALL be accepted as a normal channel-0 sample (back-to-back frames), with no error.
REQ-021 In RECV with b1_b0 = 0, a valid sample with sync low SHALL pulse sync_err, discard the sample, and move the block to HUNT; z3_z0 is unchanged.
REQ-022 In RECV with b1_b0 not 0, a valid sample with sync high SHALL pulse sync_err and discard the partial frame.
REQ-023 In that case (REQ-022), the sample SHALL be written to slot 0, b1_b0 SHALL become 1, and the block SHALL remain in RECV; z3_z0 is unchanged and frame_ok stays low.
REQ-024 The staging registers SHALL never be visible on z3_z0; z3_z0 SHALL change only on frame completion or reset.
REQ-025 frame_ok and sync_err SHALL never be high in the same cycle, and neither SHALL remain high for more than one cycle per triggering sample.
REQ-026 locked SHALL be high exactly when the state is RECV.

Reset
REQ-027 With reset high at a rising edge, the block SHALL enter HUNT with b1_b0 = 0, z3_z0 = 0, frame_ok = 0, sync_err = 0, locked = 0, and staging cleared.
REQ-028 Reset SHALL take priority over valid and sync in the same cycle; the sample in that cycle SHALL be discarded.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame with no frame_ok or sync_err pulse.
REQ-030 The block SHALL be in HUNT on the first cycle after reset deasserts.

Verification
REQ-031 Reset, then valid samples 11,22,33,44 (sync high on 11, gaps allowed) -> z3_z0 = {44,33,22,11}, frame_ok pulses once, one cycle after the 44 sample.
REQ-032 In HUNT, samples 05,06 with sync low, then sync+AA,BB,CC,DD -> 05,06 discarded; z3_z0 = {DD,CC,BB,AA}; locked rises the cycle after AA.
REQ-033 Two back-to-back frames with no idle cycles, sync on each channel-0 sample -> two frame_ok pulses four cycles apart; sync_err never asserts.
REQ-034 Mid-frame sync at slot 2 -> sync_err pulses once; previous z3_z0 is retained; the next three samples complete a new frame starting from the sync sample.
REQ-035 Missing sync at slot 0 while locked -> sync_err pulses, locked drops, sample discarded; the next sync relocks.
REQ-036 Reset asserted at slot 2, simultaneous with valid and sync -> all outputs 0 the next cycle, state HUNT, no pulses.

Source files
------------

// File: rtl/b1to4_tdm_demuxer.sv
// 1-to-4 TDM demultiplexer: collects four channel samples per frame from a
// time-multiplexed stream, aligning on a frame marker and publishing whole frames.
module b1to4_tdm_demuxer #(
  parameter int unsigned W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [W-1:0]     x0,
  input  logic             valid,
  input  logic             sync,
  output logic [4*W-1:0]   z3_z0,
  output logic [1:0]       b1_b0,
  output logic             frame_ok,
  output logic             sync_err,
  output logic             locked
);

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [W-1:0]     stage_q [3];
  logic [W-1:0]     stage_d [3];
  logic [4*W-1:0]   frame_q, frame_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_HUNT;
      slot_q  <= 2'd0;
      stage_q <= '{default: '0};
      frame_q <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      stage_q <= stage_d;
      frame_q <= frame_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  // Next-state: the slot-3 sample bypasses staging straight into the frame
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    stage_d = stage_q;
    frame_d = frame_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;

    if (valid) begin
      unique case (state_q)
        ST_HUNT: begin
          if (sync) begin
            stage_d[0] = x0;
            slot_d     = 2'd1;
            state_d    = ST_RECV;
          end
        end
        ST_RECV: begin
          if (slot_q == 2'd0) begin
            if (sync) begin
              stage_d[0] = x0;
              slot_d     = 2'd1;
            end else begin
              err_d   = 1'b1;
              state_d = ST_HUNT;
            end
          end else if (sync) begin
            // Marker mid-frame: drop the partial frame and restart on this sample
            err_d      = 1'b1;
            stage_d[0] = x0;
            slot_d     = 2'd1;
          end else begin
            unique case (slot_q)
              2'd1: begin
                stage_d[1] = x0;
                slot_d     = 2'd2;
              end
              2'd2: begin
                stage_d[2] = x0;
                slot_d     = 2'd3;
              end
              default: begin
                frame_d = {x0, stage_q[2], stage_q[1], stage_q[0]};
                ok_d    = 1'b1;
                slot_d  = 2'd0;
              end
            endcase
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  assign z3_z0    = frame_q;
  assign b1_b0    = slot_q;
  assign frame_ok = ok_q;
  assign sync_err = err_q;
  assign locked   = (state_q == ST_RECV);

endmodule

// File: tb/tb_b1to4_tdm_demuxer.sv
// Directed bench for b1to4_tdm_demuxer: expected frames queued at stimulus time,
// popped and compared whenever frame_ok is observed.
module tb_b1to4_tdm_demuxer;

  localparam int unsigned W = 8;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [W-1:0]   x0 = '0;
  logic           valid = 1'b0;
  logic           sync = 1'b0;
  logic [4*W-1:0] z3_z0;
  logic [1:0]     b1_b0;
  logic           frame_ok;
  logic           sync_err;
  logic           locked;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_ok  = 0;
  int n_err = 0;
  logic prev_ok  = 1'b0;
  logic prev_err = 1'b0;
  logic [4*W-1:0] exp_q [$];
  int ok_cyc [$];

  b1to4_tdm_demuxer #(.W(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .x0       (x0),
    .valid    (valid),
    .sync     (sync),
    .z3_z0    (z3_z0),
    .b1_b0    (b1_b0),
    .frame_ok (frame_ok),
    .sync_err (sync_err),
    .locked   (locked)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs; returns #1 after the edge that consumed them
  task automatic drive(input logic r, input logic v, input logic s, input logic [W-1:0] x);
    reset = r; valid = v; sync = s; x0 = x;
    @(posedge clock);
    #1;
    reset = 1'b0; valid = 1'b0; sync = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Scoreboard and pulse monitor
  always @(negedge clock) begin
    logic [4*W-1:0] e;
    cyc++;
    if (frame_ok || sync_err) chk("pulse_exclusive", 64'(frame_ok & sync_err), 64'd0);
    if (frame_ok && prev_ok) chk("frame_ok_width", 64'(prev_ok & frame_ok), 64'd0);
    if (sync_err && prev_err) chk("sync_err_width", 64'(prev_err & sync_err), 64'd0);
    if (sync_err) n_err++;
    if (frame_ok) begin
      n_ok++;
      ok_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_unexpected_frame observed=%0h expected=none", z3_z0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_frame", 64'(z3_z0), 64'(e));
      end
    end
    prev_ok  = frame_ok;
    prev_err = sync_err;
  end

  initial begin
    int c0;
    // Reset state
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    chk("rst_z", 64'(z3_z0), 64'd0);
    chk("rst_b", 64'(b1_b0), 64'd0);
    chk("rst_ok", 64'(frame_ok), 64'd0);
    chk("rst_err", 64'(sync_err), 64'd0);
    chk("rst_lock", 64'(locked), 64'd0);

    // Basic frame with gaps
    drive(1'b0, 1'b1, 1'b1, 8'h11);
    chk("f1_lock", 64'(locked), 64'd1);
    chk("f1_b1", 64'(b1_b0), 64'd1);
    idle();
    chk("f1_gap_b", 64'(b1_b0), 64'd1);
    drive(1'b0, 1'b1, 1'b0, 8'h22);
    idle();
    drive(1'b0, 1'b1, 1'b0, 8'h33);
    chk("f1_b3", 64'(b1_b0), 64'd3);
    chk("f1_z_hidden", 64'(z3_z0), 64'd0);
    exp_q.push_back({8'h44, 8'h33, 8'h22, 8'h11});
    drive(1'b0, 1'b1, 1'b0, 8'h44);
    chk("f1_ok", 64'(frame_ok), 64'd1);
    chk("f1_z", 64'(z3_z0), 64'h44332211);
    chk("f1_wrap", 64'(b1_b0), 64'd0);
    idle();
    chk("f1_ok_drop", 64'(frame_ok), 64'd0);
    chk("f1_z_hold", 64'(z3_z0), 64'h44332211);
    chk("f1_still_lock", 64'(locked), 64'd1);

    // HUNT discards unmarked samples
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    chk("h_unlock", 64'(locked), 64'd0);
    drive(1'b0, 1'b1, 1'b0, 8'h05);
    drive(1'b0, 1'b1, 1'b0, 8'h06);
    chk("h_disc_b", 64'(b1_b0), 64'd0);
    chk("h_disc_lock", 64'(locked), 64'd0);
    chk("h_disc_err", 64'(sync_err), 64'd0);
    drive(1'b0, 1'b1, 1'b1, 8'hAA);
    chk("h_lock", 64'(locked), 64'd1);
    drive(1'b0, 1'b1, 1'b0, 8'hBB);
    drive(1'b0, 1'b1, 1'b0, 8'hCC);
    exp_q.push_back({8'hDD, 8'hCC, 8'hBB, 8'hAA});
    drive(1'b0, 1'b1, 1'b0, 8'hDD);
    chk("h_z", 64'(z3_z0), 64'hDDCCBBAA);

    // Back-to-back frames
    c0 = n_err;
    exp_q.push_back({8'h04, 8'h03, 8'h02, 8'h01});
    exp_q.push_back({8'h08, 8'h07, 8'h06, 8'h05});
    drive(1'b0, 1'b1, 1'b1, 8'h01);
    drive(1'b0, 1'b1, 1'b0, 8'h02);
    drive(1'b0, 1'b1, 1'b0, 8'h03);
    drive(1'b0, 1'b1, 1'b0, 8'h04);
    drive(1'b0, 1'b1, 1'b1, 8'h05);
    drive(1'b0, 1'b1, 1'b0, 8'h06);
    drive(1'b0, 1'b1, 1'b0, 8'h07);
    drive(1'b0, 1'b1, 1'b0, 8'h08);
    idle();
    chk("b2b_count", 64'(ok_cyc.size()), 64'd4);
    if (ok_cyc.size() == 4) chk("b2b_spacing", 64'(ok_cyc[3] - ok_cyc[2]), 64'd4);
    chk("b2b_no_err", 64'(n_err - c0), 64'd0);

    // Marker at slot 2
    drive(1'b0, 1'b1, 1'b1, 8'h10);
    drive(1'b0, 1'b1, 1'b0, 8'h20);
    drive(1'b0, 1'b1, 1'b1, 8'h30);
    chk("mid_err", 64'(sync_err), 64'd1);
    chk("mid_b", 64'(b1_b0), 64'd1);
    chk("mid_lock", 64'(locked), 64'd1);
    chk("mid_z", 64'(z3_z0), 64'h08070605);
    chk("mid_ok", 64'(frame_ok), 64'd0);
    drive(1'b0, 1'b1, 1'b0, 8'h40);
    chk("mid_err_drop", 64'(sync_err), 64'd0);
    drive(1'b0, 1'b1, 1'b0, 8'h50);
    exp_q.push_back({8'h60, 8'h50, 8'h40, 8'h30});
    drive(1'b0, 1'b1, 1'b0, 8'h60);
    chk("mid_z_new", 64'(z3_z0), 64'h60504030);

    // Missing marker at slot 0
    drive(1'b0, 1'b1, 1'b0, 8'h77);
    chk("miss_err", 64'(sync_err), 64'd1);
    chk("miss_lock", 64'(locked), 64'd0);
    chk("miss_b", 64'(b1_b0), 64'd0);
    chk("miss_z", 64'(z3_z0), 64'h60504030);
    drive(1'b0, 1'b1, 1'b1, 8'h81);
    chk("relock", 64'(locked), 64'd1);
    chk("relock_err", 64'(sync_err), 64'd0);
    drive(1'b0, 1'b1, 1'b0, 8'h82);
    drive(1'b0, 1'b1, 1'b0, 8'h83);
    exp_q.push_back({8'h84, 8'h83, 8'h82, 8'h81});
    drive(1'b0, 1'b1, 1'b0, 8'h84);

    // Reset at slot 2 with valid and sync
    drive(1'b0, 1'b1, 1'b1, 8'h91);
    drive(1'b0, 1'b1, 1'b0, 8'h92);
    chk("rs_pre_b", 64'(b1_b0), 64'd2);
    drive(1'b1, 1'b1, 1'b1, 8'h93);
    chk("rs_z", 64'(z3_z0), 64'd0);
    chk("rs_b", 64'(b1_b0), 64'd0);
    chk("rs_ok", 64'(frame_ok), 64'd0);
    chk("rs_err", 64'(sync_err), 64'd0);
    chk("rs_lock", 64'(locked), 64'd0);
    drive(1'b0, 1'b1, 1'b0, 8'h94);
    chk("rs_hunt_b", 64'(b1_b0), 64'd0);
    chk("rs_hunt_lock", 64'(locked), 64'd0);
    chk("rs_hunt_err", 64'(sync_err), 64'd0);
    idle();
    idle();

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    chk("ok_total", 64'(n_ok), 64'd6);
    chk("err_total", 64'(n_err), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
